// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if
//   Bundles every signal between the SRAM port arbiter and its neighbours:
//   the renderer write channel, the display read channel, the SRAM
//   controller port and the drained status flag.
//
//   Write channel  : wr_valid, wr_addr, wr_data -> arbiter; wr_ready <- arbiter
//   Read channel   : rd_req, rd_addr -> arbiter; rd_data, rd_data_valid <- arbiter
//   SRAM port      : sram_read_enable, sram_write_enable, sram_addr,
//                    sram_write_data <- arbiter; sram_read_data -> arbiter
//   Status         : drained <- arbiter
//
//   Modports
//     slave  : the arbiter's view
//     master : the surrounding system (renderer, display, SRAM controller)
interface sram_port_arbiter_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;

    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_data_valid;

    logic              sram_read_enable;
    logic              sram_write_enable;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_write_data;
    logic [DATA_W-1:0] sram_read_data;

    logic              drained;

    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_req, rd_addr, sram_read_data,
        output wr_ready, rd_data, rd_data_valid,
        output sram_read_enable, sram_write_enable, sram_addr, sram_write_data,
        output drained
    );

    modport master (
        output wr_valid, wr_addr, wr_data, rd_req, rd_addr, sram_read_data,
        input  wr_ready, rd_data, rd_data_valid,
        input  sram_read_enable, sram_write_enable, sram_addr, sram_write_data,
        input  drained
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares the single SRAM controller port between the renderer (pixel
//   writes) and the display controller (scan-out reads). Renderer writes are
//   buffered in a DEPTH-entry FIFO; a display read request always wins the
//   port, and queued writes use every cycle without a read. Read data comes
//   back in request order 2+READ_LATENCY cycles after the request. The
//   drained flag tells the frame/swap logic that every accepted write has
//   been issued to SRAM.
//
//   Ports
//     clock : system clock, rising edge
//     reset : asynchronous, active-low
//     bus   : sram_port_arbiter_if.slave (write channel, read channel,
//             SRAM port, drained)
//
//   Parameters
//     DEPTH        : write FIFO entries, power of two, >= 2
//     ADDR_W       : SRAM word address width (must match bus)
//     DATA_W       : SRAM data width (must match bus)
//     READ_LATENCY : SRAM cycles from read enable to valid read data, >= 1
module sram_port_arbiter #(
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 20,
    parameter int DATA_W       = 16,
    parameter int READ_LATENCY = 2
) (
    input  logic               clock,
    input  logic               reset,
    sram_port_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

    // Port decision for the current cycle; it takes effect on the SRAM port
    // in the next cycle.
    typedef enum logic [1:0] {
        OP_IDLE,
        OP_READ,
        OP_WRITE
    } op_e;

    wr_entry_t         fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              wr_ready;
    logic              push;
    logic              pop;
    wr_entry_t         head;
    op_e               op;

    logic              sram_read_enable_q;
    logic              sram_write_enable_q;
    logic [ADDR_W-1:0] sram_addr_q;
    logic [DATA_W-1:0] sram_write_data_q;
    logic              drained_q;
    // Bits [READ_LATENCY-1:0] track reads inside the SRAM; the top bit is
    // the rd_data_valid pulse itself.
    logic [READ_LATENCY:0] rd_valid_pipe;
    logic [DATA_W-1:0] rd_data_q;

    // Ready depends on the registered count only, so a full FIFO refuses a
    // push even in a cycle where it also pops.
    assign wr_ready = (count != FULL_COUNT);
    assign push     = bus.wr_valid & wr_ready;
    assign head     = fifo_mem[rd_ptr];

    always_comb begin
        // NOTE: op gets a default before any branch so every path assigns it;
        // without it an unassigned path would infer a latch.
        op = OP_IDLE;
        if (bus.rd_req) begin
            op = OP_READ;
        end else if (count != '0) begin
            // count is registered, so an entry pushed this cycle is not yet
            // visible here: no fall-through.
            op = OP_WRITE;
        end
    end

    assign pop = (op == OP_WRITE);

    // NOTE: the FIFO storage has no reset; pointers and count define which
    // entries are live, so clearing the array would only cost reset fan-out.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{addr: bus.wr_addr, data: bus.wr_data};
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr              <= '0;
            rd_ptr              <= '0;
            count               <= '0;
            sram_read_enable_q  <= 1'b0;
            sram_write_enable_q <= 1'b0;
            sram_addr_q         <= '0;
            sram_write_data_q   <= '0;
            drained_q           <= 1'b1;
        end else begin
            // Pointers are PTR_W bits wide, so they wrap modulo DEPTH.
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (!push && pop) begin
                count <= count - CNT_W'(1);
            end

            unique case (op)
                OP_READ: begin
                    sram_read_enable_q  <= 1'b1;
                    sram_write_enable_q <= 1'b0;
                    sram_addr_q         <= bus.rd_addr;
                end
                OP_WRITE: begin
                    sram_read_enable_q  <= 1'b0;
                    sram_write_enable_q <= 1'b1;
                    sram_addr_q         <= head.addr;
                    sram_write_data_q   <= head.data;
                end
                default: begin
                    // Address and data hold; only the enables drop.
                    sram_read_enable_q  <= 1'b0;
                    sram_write_enable_q <= 1'b0;
                end
            endcase

            // A pending wr_valid keeps drained low even before it is accepted.
            drained_q <= (count == '0) & ~pop & ~bus.wr_valid;
        end
    end

    // Read return: the valid bit follows the read enable through the SRAM
    // latency; the data is captured on the cycle the SRAM presents it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_valid_pipe <= '0;
            rd_data_q     <= '0;
        end else begin
            rd_valid_pipe <= {rd_valid_pipe[READ_LATENCY-1:0], sram_read_enable_q};
            if (rd_valid_pipe[READ_LATENCY-1]) begin
                rd_data_q <= bus.sram_read_data;
            end
        end
    end

    assign bus.wr_ready          = wr_ready;
    assign bus.sram_read_enable  = sram_read_enable_q;
    assign bus.sram_write_enable = sram_write_enable_q;
    assign bus.sram_addr         = sram_addr_q;
    assign bus.sram_write_data   = sram_write_data_q;
    assign bus.drained           = drained_q;
    assign bus.rd_data           = rd_data_q;
    assign bus.rd_data_valid     = rd_valid_pipe[READ_LATENCY];
endmodule
